// File: rtl/bexkat1_dbus_io.sv
// rtl/bexkat1_dbus_io.sv - bexkat1p data-bus I/O slave: console TX FIFO, cycle counter, scratch, exit
module bexkat1_dbus_io #(
   parameter int DEPTH  = 16,
   parameter int CWIDTH = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [2:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        exit_o,
   output logic [7:0]  exit_code_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       count;
   logic              overflow;
   logic [CWIDTH-1:0] counter;
   logic [31:0]       shadow;
   logic [31:0]       scratch;
   logic [31:0]       rd_data;

   logic accept;
   logic empty;
   logic full;
   logic pop;
   logic push_req;
   logic push;
   logic ovf_set;
   logic ovf_clr;

   // An access is taken only when no ack is outstanding, giving one access per two cycles.
   assign accept   = cyc_i & stb_i & ~ack_o;
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop      = ~empty & tx_ready_i;
   assign push_req = accept & we_i & (adr_i == 3'd0) & sel_i[0];
   // A push into a full FIFO still fits when the head leaves on the same edge.
   assign push     = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;
   assign ovf_clr  = accept & we_i & (adr_i == 3'd1) & sel_i[0] & dat_i[2];

   assign tx_valid_o  = ~empty;
   assign tx_data_o   = empty ? 8'h00 : mem[rd_ptr];

   // Read-data mux for the register map; unmapped offsets read zero.
   always_comb begin
      rd_data = 32'h0;
      case (adr_i)
         3'd1:    rd_data = {16'h0, 8'(count), 5'h0, overflow, full, empty};
         3'd2:    rd_data = counter[31:0];
         3'd3:    rd_data = shadow;
         3'd4:    rd_data = {23'h0, exit_o, exit_code_o};
         3'd5:    rd_data = scratch;
         default: rd_data = 32'h0;
      endcase
   end

   // Bus response: one-cycle ack with read data, zero data for writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o <= 1'b0;
         dat_o <= 32'h0;
      end else begin
         ack_o <= accept;
         dat_o <= (accept & ~we_i) ? rd_data : 32'h0;
      end
   end

   // FIFO storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= dat_i[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;
         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   // Free-running counter; reading LO snapshots HI so a later HI read is coherent.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         counter <= '0;
         shadow  <= 32'h0;
      end else begin
         counter <= counter + 1'b1;
         if (accept & ~we_i & (adr_i == 3'd2))
            shadow <= counter[63:32];
      end
   end

   // Scratch register with byte-lane masking, and the sticky exit register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scratch     <= 32'h0;
         exit_o      <= 1'b0;
         exit_code_o <= 8'h0;
      end else if (accept & we_i) begin
         if (adr_i == 3'd5) begin
            for (int b = 0; b < 4; b++)
               if (sel_i[b])
                  scratch[8*b +: 8] <= dat_i[8*b +: 8];
         end
         if ((adr_i == 3'd4) && sel_i[0]) begin
            exit_o      <= 1'b1;
            exit_code_o <= dat_i[7:0];
         end
      end
   end

endmodule

// File: doc/bexkat1_dbus_io.md
Name: bexkat1_dbus_io

Overview:
Wishbone-style memory-mapped I/O slave for the bexkat1p data bus, placed beside the dual-port RAM and decoded by upper address bits in the simulation top. Provides a console byte TX FIFO with a streaming output, a 64-bit free-running cycle counter with coherent readout, a scratch register and a sticky simulation-exit register. The Verilator harness consumes the TX stream and the exit signals.

Parameters:
DEPTH, 16, TX FIFO entries; power of two, 2..256
CWIDTH, 64, cycle counter width; fixed 64 in this revision

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous reset, active-high
cyc_i  input  1  bus cycle valid
stb_i  input  1  strobe; access requested when cyc_i&stb_i
we_i  input  1  1=write, 0=read
sel_i  input  4  byte lanes; sel_i[0]=dat[7:0]
adr_i  input  3  word offset (CPU adr[4:2])
dat_i  input  32  write data
dat_o  output  32  read data, valid while ack_o=1
ack_o  output  1  single-cycle acknowledge
tx_data_o  output  8  FIFO head byte
tx_valid_o  output  1  FIFO not empty
tx_ready_i  input  1  consumer accepts head when tx_valid_o&tx_ready_i
exit_o  output  1  sticky; harness stops simulation
exit_code_o  output  8  value written to EXIT

Behaviour:
- Reset (rst_i=1 at edge): ack_o=0, dat_o=0, FIFO empty (tx_valid_o=0, tx_data_o=0), overflow=0, counter=0, shadow=0, scratch=0, exit_o=0, exit_code_o=0. Reset mid-access drops the access: no ack, no side effect.
- Handshake: access accepted at an edge where cyc_i&stb_i&!ack_o; side effects commit at that edge; ack_o=1 the following cycle for exactly one cycle, dat_o valid with it. Request held high gets ack every other cycle (one access per two cycles). cyc_i dropped before ack: the accepted access still completes and acks.
- dat_o returns 0 whenever ack_o=0 and for writes.
- Register map (word offset):
  0 TXDATA W: if sel_i[0], push dat_i[7:0]; read returns 0.
  1 STATUS R: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count (zero-extended), others 0. W: dat_i[2]=1 with sel_i[0] clears overflow.
  2 CYCLE_LO R: counter[31:0] at accept edge; same edge loads shadow<=counter[63:32].
  3 CYCLE_HI R: shadow. Writes to 2/3 ignored.
  4 EXIT W: sel_i[0] sets exit_o=1, exit_code_o=dat_i[7:0]; later writes update exit_code_o; exit_o stays 1 until reset. R: {23'b0,exit_o,exit_code_o}.
  5 SCRATCH R/W with per-byte sel_i masking.
  6,7: read 0, writes ignored, still acked.
- Counter: increments by 1 every non-reset cycle, wraps 2^64-1 -> 0.
- FIFO: circular buffer, pointers log2(DEPTH) bits wrapping, count log2(DEPTH)+1 bits. tx_data_o = head (registered RAM or mux, 0 when empty). Pop when tx_valid_o&tx_ready_i.
- Push when full: if pop occurs same cycle, push accepted (count unchanged); otherwise byte dropped and overflow set (sticky). Push and pop same cycle when not full/not empty: count unchanged. Push when empty: tx_valid_o=1 the next cycle (no bypass).
- Overflow set and clear in same cycle: set wins.

Test Plan:
- Reset then read offset 1 -> ack one cycle after request, dat_o=0x00000001; read offsets 6,7 -> 0.
- tx_ready_i=0, write 0x41,0x42,0x43 to TXDATA -> STATUS count=3; raise tx_ready_i -> tx_data_o 0x41,0x42,0x43 on consecutive cycles, then tx_valid_o=0.
- tx_ready_i=0, 17 writes (DEPTH=16) -> STATUS=0x00001006 (count 16, full, overflow); write 0x4 to STATUS -> overflow clears; full-with-pop push accepted, count stays 16.
- Force counter near 0x00000000_FFFFFFFF, read LO then HI across carry -> HI equals value latched at LO read, not post-carry; counter wraps from all-ones to 0.
- Write 0xA5 to EXIT -> exit_o=1, exit_code_o=0xA5 one cycle after accept; persists until rst_i.
- SCRATCH: write 0xDEADBEEF sel=0xF, then 0x00000012 sel=0x1 -> read 0xDEADBE12; assert rst_i during pending access -> no ack, scratch=0.
